// File: rtl/fpu_fflags_csr_if.sv
// CSR access bus between the privileged CSR unit (master) and the fp CSR block (slave).
interface fpu_fflags_csr_if #(parameter int XLEN = 64);
    logic            CSRWriteW;
    logic [1:0]      CSROpW;
    logic [11:0]     CSRAdrW;
    logic [XLEN-1:0] CSRSrcW;
    logic [XLEN-1:0] CSRReadValW;
    logic            CSRHitW;

    modport master (output CSRWriteW, CSROpW, CSRAdrW, CSRSrcW,
                    input  CSRReadValW, CSRHitW);
    modport slave  (input  CSRWriteW, CSROpW, CSRAdrW, CSRSrcW,
                    output CSRReadValW, CSRHitW);
endinterface

// File: rtl/fpu_fflags_csr.sv
// Architectural fcsr state: sticky fflags, frm, M->W flag pipe register,
// CSR access to fflags/frm/fcsr and dynamic rounding-mode resolution for decode.
module fpu_fflags_csr #(
    parameter int XLEN = 64
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                StallW,
    input  logic                FlushW,
    input  logic                FpuFlagValidM,
    input  logic [4:0]          SetFflagsM,
    fpu_fflags_csr_if.slave     csr,
    input  logic [2:0]          InstrFrmD,
    output logic [4:0]          FFlags,
    output logic [2:0]          FRM,
    output logic [2:0]          FRmD,
    output logic                IllegalFRmD,
    output logic                FSDirtyW
);
    localparam logic [11:0] ADR_FFLAGS = 12'h001;
    localparam logic [11:0] ADR_FRM    = 12'h002;
    localparam logic [11:0] ADR_FCSR   = 12'h003;

    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_SET   = 2'b10;
    localparam logic [1:0] OP_CLEAR = 2'b11;

    logic       flagValidW;
    logic [4:0] flagsW;
    logic       hit;
    logic [7:0] cur8;
    logic [7:0] src8;
    logic [7:0] new8;
    logic       csrUpd;
    logic       flagCommit;
    logic       unusedSrcHi;

    // Only the low byte of the source can reach any fp CSR field.
    assign src8        = csr.CSRSrcW[7:0];
    assign unusedSrcHi = ^csr.CSRSrcW[XLEN-1:8];

    // Address decode, current field value (also the read data) and the new value.
    always_comb begin
        hit  = 1'b0;
        cur8 = 8'h00;
        case (csr.CSRAdrW)
            ADR_FFLAGS: begin hit = 1'b1; cur8 = {3'b000, FFlags}; end
            ADR_FRM:    begin hit = 1'b1; cur8 = {5'b00000, FRM};  end
            ADR_FCSR:   begin hit = 1'b1; cur8 = {FRM, FFlags};    end
            default:    begin hit = 1'b0; cur8 = 8'h00;            end
        endcase
        case (csr.CSROpW)
            OP_WRITE: new8 = src8;
            OP_SET:   new8 = cur8 | src8;
            OP_CLEAR: new8 = cur8 & ~src8;
            default:  new8 = cur8;
        endcase
    end

    assign csr.CSRHitW     = hit;
    assign csr.CSRReadValW = {{(XLEN-8){1'b0}}, cur8};

    // Reset gating keeps the dirty pulse quiet while state is being cleared.
    assign csrUpd     = ~reset & ~StallW & csr.CSRWriteW & hit & (csr.CSROpW != 2'b00);
    assign flagCommit = ~reset & ~StallW & flagValidW;
    assign FSDirtyW   = csrUpd | (flagCommit & (|flagsW));

    // M->W flag register; a flush kills the entering op even while W is stalled.
    always_ff @(posedge clk) begin
        if (reset) begin
            flagValidW <= 1'b0;
            flagsW     <= 5'b00000;
        end else if (FlushW) begin
            flagValidW <= 1'b0;
        end else if (!StallW) begin
            flagValidW <= FpuFlagValidM;
            flagsW     <= SetFflagsM;
        end
    end

    // Architectural state; a CSR update wins over (and drops) a same-cycle flag commit.
    always_ff @(posedge clk) begin
        if (reset) begin
            FFlags <= 5'b00000;
            FRM    <= 3'b000;
        end else if (csrUpd) begin
            case (csr.CSRAdrW)
                ADR_FFLAGS: FFlags <= new8[4:0];
                ADR_FRM:    FRM    <= new8[2:0];
                default: begin
                    FFlags <= new8[4:0];
                    FRM    <= new8[7:5];
                end
            endcase
        end else if (flagCommit) begin
            FFlags <= FFlags | flagsW;
        end
    end

    // Dynamic rounding mode uses the registered frm; frm hazards are the pipeline's job.
    always_comb begin
        FRmD        = (InstrFrmD == 3'b111) ? FRM : InstrFrmD;
        IllegalFRmD = (FRmD == 3'b101) || (FRmD == 3'b110) || (FRmD == 3'b111);
    end

    // A legal pipeline never retires a CSR write and an FP op in the same W cycle.
    assert property (@(posedge clk) disable iff (reset) !(csrUpd && flagCommit));

endmodule

// File: tb/tb_fpu_fflags_csr.sv
// Self-checking bench for fpu_fflags_csr: vector table plus reset sequences,
// with post-edge architectural state checked through a scoreboard queue.
module tb_fpu_fflags_csr;
    logic        clk = 1'b0;
    logic        reset;
    logic        StallW, FlushW, FpuFlagValidM;
    logic [4:0]  SetFflagsM;
    logic [2:0]  InstrFrmD;
    logic [4:0]  FFlags;
    logic [2:0]  FRM, FRmD;
    logic        IllegalFRmD, FSDirtyW;

    fpu_fflags_csr_if #(.XLEN(64)) csrBus();

    fpu_fflags_csr #(.XLEN(64)) dut (
        .clk(clk), .reset(reset), .StallW(StallW), .FlushW(FlushW),
        .FpuFlagValidM(FpuFlagValidM), .SetFflagsM(SetFflagsM), .csr(csrBus),
        .InstrFrmD(InstrFrmD), .FFlags(FFlags), .FRM(FRM), .FRmD(FRmD),
        .IllegalFRmD(IllegalFRmD), .FSDirtyW(FSDirtyW)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        stall, flush, fv;
        logic [4:0]  fl;
        logic        cw;
        logic [1:0]  op;
        logic [11:0] adr;
        logic [63:0] src;
        logic [2:0]  ifrm;
        logic        eDirty;
        logic [63:0] eRead;
        logic        eHit;
        logic [2:0]  eFrmD;
        logic        eIll;
        logic [4:0]  eFF;
        logic [2:0]  eFRM;
    } vec_t;

    typedef struct {
        logic [4:0] ff;
        logic [2:0] frm;
        int         idx;
    } exp_t;

    localparam int NV = 22;
    vec_t vec [NV];
    exp_t sb [$];
    int   total = 0;
    int   passed = 0;

    task automatic chk(input string name, input int idx, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s [%0d]: got 0x%0h expected 0x%0h", name, idx, act, exp);
    endtask

    task automatic drive(input logic st, input logic fls, input logic fv, input logic [4:0] fl,
                         input logic cw, input logic [1:0] op, input logic [11:0] adr,
                         input logic [63:0] src, input logic [2:0] ifrm);
        StallW = st; FlushW = fls; FpuFlagValidM = fv; SetFflagsM = fl;
        csrBus.CSRWriteW = cw; csrBus.CSROpW = op; csrBus.CSRAdrW = adr;
        csrBus.CSRSrcW = src; InstrFrmD = ifrm;
    endtask

    // Advance one clock and compare the state the scoreboard expects after it.
    task automatic tick_and_pop();
        exp_t e;
        @(posedge clk);
        @(negedge clk);
        if (sb.size() == 0) begin
            total++;
            $display("FAIL scoreboard: empty queue");
        end else begin
            e = sb.pop_front();
            chk("FFlags", e.idx, {59'd0, FFlags}, {59'd0, e.ff});
            chk("FRM",    e.idx, {61'd0, FRM},    {61'd0, e.frm});
        end
    endtask

    initial begin
        //          st fl fv fl      cw op     adr      src                     ifrm   dty read    hit frmD  ill ff       frm
        vec[0]  = '{0, 0, 1, 5'h01, 0, 2'b00, 12'h003, 64'h0,                 3'd0, 0, 64'h00, 1, 3'd0, 0, 5'h00, 3'd0};
        vec[1]  = '{0, 0, 1, 5'h10, 0, 2'b00, 12'h003, 64'h0,                 3'd0, 1, 64'h00, 1, 3'd0, 0, 5'h01, 3'd0};
        vec[2]  = '{1, 0, 0, 5'h00, 0, 2'b00, 12'h003, 64'h0,                 3'd0, 0, 64'h01, 1, 3'd0, 0, 5'h01, 3'd0};
        vec[3]  = '{1, 0, 0, 5'h00, 0, 2'b00, 12'h003, 64'h0,                 3'd0, 0, 64'h01, 1, 3'd0, 0, 5'h01, 3'd0};
        vec[4]  = '{1, 0, 0, 5'h00, 0, 2'b00, 12'h003, 64'h0,                 3'd0, 0, 64'h01, 1, 3'd0, 0, 5'h01, 3'd0};
        vec[5]  = '{0, 0, 0, 5'h00, 0, 2'b00, 12'h003, 64'h0,                 3'd0, 1, 64'h01, 1, 3'd0, 0, 5'h11, 3'd0};
        vec[6]  = '{1, 1, 1, 5'h04, 0, 2'b00, 12'h003, 64'h0,                 3'd0, 0, 64'h11, 1, 3'd0, 0, 5'h11, 3'd0};
        vec[7]  = '{0, 0, 0, 5'h00, 0, 2'b00, 12'h003, 64'h0,                 3'd0, 0, 64'h11, 1, 3'd0, 0, 5'h11, 3'd0};
        vec[8]  = '{0, 0, 1, 5'h04, 0, 2'b00, 12'h003, 64'h0,                 3'd0, 0, 64'h11, 1, 3'd0, 0, 5'h11, 3'd0};
        vec[9]  = '{1, 1, 0, 5'h00, 0, 2'b00, 12'h003, 64'h0,                 3'd0, 0, 64'h11, 1, 3'd0, 0, 5'h11, 3'd0};
        vec[10] = '{0, 0, 0, 5'h00, 0, 2'b00, 12'h003, 64'h0,                 3'd0, 0, 64'h11, 1, 3'd0, 0, 5'h11, 3'd0};
        vec[11] = '{0, 0, 0, 5'h00, 1, 2'b01, 12'h003, 64'hE5,                3'd0, 1, 64'h11, 1, 3'd0, 0, 5'h05, 3'd7};
        vec[12] = '{0, 0, 0, 5'h00, 1, 2'b11, 12'h001, 64'h04,                3'd0, 1, 64'h05, 1, 3'd0, 0, 5'h01, 3'd7};
        vec[13] = '{0, 0, 0, 5'h00, 0, 2'b00, 12'h003, 64'h0,                 3'd7, 0, 64'hE1, 1, 3'd7, 1, 5'h01, 3'd7};
        vec[14] = '{0, 0, 0, 5'h00, 0, 2'b00, 12'h002, 64'h0,                 3'd2, 0, 64'h07, 1, 3'd2, 0, 5'h01, 3'd7};
        vec[15] = '{0, 0, 0, 5'h00, 1, 2'b10, 12'h001, 64'hFFFFFF0000000012,  3'd0, 1, 64'h01, 1, 3'd0, 0, 5'h13, 3'd7};
        vec[16] = '{0, 0, 0, 5'h00, 1, 2'b01, 12'h002, 64'h0A,                3'd7, 1, 64'h07, 1, 3'd7, 1, 5'h13, 3'd2};
        vec[17] = '{0, 0, 0, 5'h00, 1, 2'b01, 12'h004, 64'hFF,                3'd7, 0, 64'h00, 0, 3'd2, 0, 5'h13, 3'd2};
        vec[18] = '{0, 0, 0, 5'h00, 1, 2'b00, 12'h001, 64'h1F,                3'd5, 0, 64'h13, 1, 3'd5, 1, 5'h13, 3'd2};
        vec[19] = '{1, 0, 0, 5'h00, 1, 2'b01, 12'h001, 64'h1F,                3'd6, 0, 64'h13, 1, 3'd6, 1, 5'h13, 3'd2};
        vec[20] = '{0, 0, 0, 5'h00, 1, 2'b01, 12'h001, 64'h1F,                3'd0, 1, 64'h13, 1, 3'd0, 0, 5'h1F, 3'd2};
        vec[21] = '{0, 0, 1, 5'h02, 0, 2'b00, 12'h003, 64'h0,                 3'd0, 0, 64'h5F, 1, 3'd0, 0, 5'h1F, 3'd2};

        // Reset state, asserted while flags are offered.
        reset = 1'b1;
        drive(1'b0, 1'b0, 1'b1, 5'h1F, 1'b0, 2'b00, 12'h003, 64'h0, 3'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 5'h00, 1'b0, 2'b00, 12'h003, 64'h0, 3'd0);
        #1;
        chk("rst_FFlags", -1, {59'd0, FFlags}, 64'h0);
        chk("rst_FRM",    -1, {61'd0, FRM},    64'h0);
        chk("rst_dirty",  -1, {63'd0, FSDirtyW}, 64'h0);
        chk("rst_read",   -1, csrBus.CSRReadValW, 64'h0);
        @(negedge clk);

        for (int i = 0; i < NV; i++) begin
            drive(vec[i].stall, vec[i].flush, vec[i].fv, vec[i].fl, vec[i].cw,
                  vec[i].op, vec[i].adr, vec[i].src, vec[i].ifrm);
            #1;
            chk("FSDirtyW",    i, {63'd0, FSDirtyW},    {63'd0, vec[i].eDirty});
            chk("CSRReadValW", i, csrBus.CSRReadValW,   vec[i].eRead);
            chk("CSRHitW",     i, {63'd0, csrBus.CSRHitW}, {63'd0, vec[i].eHit});
            chk("FRmD",        i, {61'd0, FRmD},        {61'd0, vec[i].eFrmD});
            chk("IllegalFRmD", i, {63'd0, IllegalFRmD}, {63'd0, vec[i].eIll});
            sb.push_back('{vec[i].eFF, vec[i].eFRM, i});
            tick_and_pop();
        end

        // Reset while stalled with a valid flag held in W: everything clears, no dirty pulse.
        reset = 1'b1;
        drive(1'b1, 1'b0, 1'b1, 5'h04, 1'b0, 2'b00, 12'h003, 64'h0, 3'd0);
        #1;
        chk("rstmid_dirty", 100, {63'd0, FSDirtyW}, 64'h0);
        sb.push_back('{5'h00, 3'd0, 100});
        tick_and_pop();
        reset = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 5'h00, 1'b0, 2'b00, 12'h003, 64'h0, 3'd0);
        #1;
        chk("rstmid_dirty2", 101, {63'd0, FSDirtyW}, 64'h0);
        chk("rstmid_read",   101, csrBus.CSRReadValW, 64'h0);
        sb.push_back('{5'h00, 3'd0, 101});
        tick_and_pop();

        // Reset during a flush behaves the same.
        drive(1'b0, 1'b0, 1'b1, 5'h08, 1'b0, 2'b00, 12'h003, 64'h0, 3'd0);
        sb.push_back('{5'h00, 3'd0, 102});
        tick_and_pop();
        reset = 1'b1;
        drive(1'b0, 1'b1, 1'b1, 5'h08, 1'b0, 2'b00, 12'h003, 64'h0, 3'd0);
        #1;
        chk("rstflush_dirty", 103, {63'd0, FSDirtyW}, 64'h0);
        sb.push_back('{5'h00, 3'd0, 103});
        tick_and_pop();
        reset = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 5'h00, 1'b0, 2'b00, 12'h003, 64'h0, 3'd0);
        #1;
        chk("rstflush_dirty2", 104, {63'd0, FSDirtyW}, 64'h0);
        sb.push_back('{5'h00, 3'd0, 104});
        tick_and_pop();

        chk("sb_drained", 105, 64'(sb.size()), 64'h0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
